ofm_write_scheduler: RTL and testbench

OFM_WRITE_SCHEDULER -- requirements
Module: ofm_write_scheduler

---
 rtl/ofm_sched_pkg.sv | 39 +++
 rtl/ofm_pos_counter.sv | 79 +++++++
 rtl/ofm_write_scheduler.sv | 121 ++++++++++++
 tb/tb_ofm_write_scheduler.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ofm_sched_pkg.sv
// ============================================================================
//  Module      : ofm_sched_pkg
//  Description : Shared state encoding and derived tiling constants for the
//                OFM write scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ofm_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_ADVANCE = 2'd2,
        ST_DONE    = 2'd3
    } sched_state_e;

    function automatic int calc_plane_size(input int ofm_size);
        return ofm_size * ofm_size;
    endfunction

    function automatic int calc_tiles_per_row(input int sys_size, input int ofm_size);
        return (ofm_size + sys_size - 1) / sys_size;
    endfunction

    // Width of the ragged right-hand tile of every row.
    function automatic int calc_last_tile_pixels(input int sys_size, input int ofm_size);
        return ofm_size - (calc_tiles_per_row(sys_size, ofm_size) - 1) * sys_size;
    endfunction

    localparam int DEF_SYSTOLIC_SIZE = 16;
    localparam int DEF_OFM_SIZE      = 414;
    localparam int PLANE_SIZE        = calc_plane_size(DEF_OFM_SIZE);
    localparam int TILES_PER_ROW     = calc_tiles_per_row(DEF_SYSTOLIC_SIZE, DEF_OFM_SIZE);
    localparam int LAST_TILE_PIXELS  = calc_last_tile_pixels(DEF_SYSTOLIC_SIZE, DEF_OFM_SIZE);

endpackage

`default_nettype wire

// File: rtl/ofm_pos_counter.sv
// ============================================================================
//  Module      : ofm_pos_counter
//  Description : Tracks tile column / row within the OFM and the base word
//                address of the current tile.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ofm_pos_counter
    import ofm_sched_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int OFM_SIZE      = 414,
    parameter int ADDR_WIDTH    = 22
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             advance,
    input  logic                             clear,
    output logic [ADDR_WIDTH-1:0]            base_addr,
    output logic [$clog2(SYSTOLIC_SIZE)-1:0] last_pixel,
    output logic                             last_tile
);

    localparam int TPR = calc_tiles_per_row(SYSTOLIC_SIZE, OFM_SIZE);
    localparam int LTP = calc_last_tile_pixels(SYSTOLIC_SIZE, OFM_SIZE);
    localparam int PW  = $clog2(SYSTOLIC_SIZE);
    localparam int CW  = (TPR > 1) ? $clog2(TPR) : 1;
    localparam int RW  = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  last_col;
    logic                  last_row;
    logic [ADDR_WIDTH-1:0] valid_pixels;

    assign last_col     = (col_q == CW'(TPR - 1));
    assign last_row     = (row_q == RW'(OFM_SIZE - 1));
    assign valid_pixels = last_col ? ADDR_WIDTH'(LTP) : ADDR_WIDTH'(SYSTOLIC_SIZE);
    assign last_pixel   = last_col ? PW'(LTP - 1) : PW'(SYSTOLIC_SIZE - 1);
    assign last_tile    = last_col && last_row;
    assign base_addr    = base_q;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        base_d = base_q;
        if (clear) begin
            col_d  = '0;
            row_d  = '0;
            base_d = '0;
        end else if (advance) begin
            // Stepping past the ragged last tile lands exactly on the next row start.
            base_d = base_q + valid_pixels;
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            base_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            base_q <= base_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ofm_write_scheduler.sv
// ============================================================================
//  Module      : ofm_write_scheduler
//  Description : Streams each finished systolic result tile to OFM memory,
//                channel-major, one word per accepted beat.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ofm_write_scheduler
    import ofm_sched_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int OFM_SIZE      = 414,
    parameter int ADDR_WIDTH    = 22
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             tile_ready,
    input  logic                             wr_ready,
    output logic                             wr_valid,
    output logic [ADDR_WIDTH-1:0]            ofm_addr,
    output logic [$clog2(SYSTOLIC_SIZE)-1:0] sel_channel,
    output logic [$clog2(SYSTOLIC_SIZE)-1:0] sel_pixel,
    output logic                             busy,
    output logic                             tile_done,
    output logic                             layer_done
);

    localparam int                    PW      = $clog2(SYSTOLIC_SIZE);
    localparam logic [ADDR_WIDTH-1:0] PLANE_A = ADDR_WIDTH'(calc_plane_size(OFM_SIZE));

    sched_state_e          state_q, state_d;
    logic [PW-1:0]         chan_q, chan_d;
    logic [PW-1:0]         pix_q, pix_d;
    logic [ADDR_WIDTH-1:0] chan_off_q, chan_off_d;

    logic                  pos_advance;
    logic                  pos_clear;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [PW-1:0]         last_pixel;
    logic                  last_tile;

    ofm_pos_counter #(
        .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
        .OFM_SIZE      (OFM_SIZE),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_pos (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (pos_advance),
        .clear      (pos_clear),
        .base_addr  (base_addr),
        .last_pixel (last_pixel),
        .last_tile  (last_tile)
    );

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        pix_d       = pix_q;
        chan_off_d  = chan_off_q;
        pos_advance = 1'b0;
        pos_clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tile_ready) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (wr_ready) begin
                    if (pix_q == last_pixel) begin
                        pix_d = '0;
                        if (chan_q == PW'(SYSTOLIC_SIZE - 1)) begin
                            chan_d     = '0;
                            chan_off_d = '0;
                            state_d    = ST_ADVANCE;
                        end else begin
                            chan_d     = chan_q + PW'(1);
                            chan_off_d = chan_off_q + PLANE_A;
                        end
                    end else begin
                        pix_d = pix_q + PW'(1);
                    end
                end
            end
            ST_ADVANCE: begin
                pos_advance = 1'b1;
                state_d     = last_tile ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                pos_clear = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            chan_q     <= '0;
            pix_q      <= '0;
            chan_off_q <= '0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            pix_q      <= pix_d;
            chan_off_q <= chan_off_d;
        end
    end

    assign wr_valid    = (state_q == ST_WRITE);
    assign busy        = (state_q != ST_IDLE);
    assign tile_done   = (state_q == ST_ADVANCE);
    assign layer_done  = (state_q == ST_DONE);
    assign sel_channel = chan_q;
    assign sel_pixel   = pix_q;
    assign ofm_addr    = base_addr + chan_off_q + ADDR_WIDTH'(pix_q);

endmodule

`default_nettype wire

// File: tb/tb_ofm_write_scheduler.sv
// ============================================================================
//  Module      : tb_ofm_write_scheduler
//  Description : Directed bench; default-size instance for address/handshake
//                behaviour, small instance (4x4 array, 10x10 OFM) for a layer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ofm_write_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic tr_a, wr_a, tr_b, wr_b;

    logic        wv_a, busy_a, td_a, ld_a;
    logic [21:0] addr_a;
    logic [3:0]  ch_a, px_a;

    logic        wv_b, busy_b, td_b, ld_b;
    logic [21:0] addr_b;
    logic [1:0]  ch_b, px_b;

    ofm_write_scheduler #(.SYSTOLIC_SIZE(16), .OFM_SIZE(414), .ADDR_WIDTH(22)) dut_a (
        .clk(clk), .rst_n(rst_n), .tile_ready(tr_a), .wr_ready(wr_a),
        .wr_valid(wv_a), .ofm_addr(addr_a), .sel_channel(ch_a), .sel_pixel(px_a),
        .busy(busy_a), .tile_done(td_a), .layer_done(ld_a)
    );

    ofm_write_scheduler #(.SYSTOLIC_SIZE(4), .OFM_SIZE(10), .ADDR_WIDTH(22)) dut_b (
        .clk(clk), .rst_n(rst_n), .tile_ready(tr_b), .wr_ready(wr_b),
        .wr_valid(wv_b), .ofm_addr(addr_b), .sel_channel(ch_b), .sel_pixel(px_b),
        .busy(busy_b), .tile_done(td_b), .layer_done(ld_b)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int td_cnt_a = 0;
    int ld_cnt_b = 0;

    always @(negedge clk) begin
        if (td_a === 1'b1) td_cnt_a++;
        if (ld_b === 1'b1) ld_cnt_b++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {busy, tile_done, layer_done, wr_valid, channel, pixel, addr} at bits [51:0]
    function automatic logic [63:0] snap(input bit b);
        if (b) return {12'd0, busy_b, td_b, ld_b, wv_b, 8'(ch_b), 8'(px_b), 32'(addr_b)};
        return {12'd0, busy_a, td_a, ld_a, wv_a, 8'(ch_a), 8'(px_a), 32'(addr_a)};
    endfunction

    function automatic logic [63:0] beat_exp(input int c, input int p, input int addr);
        return {12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'(c), 8'(p), 32'(addr)};
    endfunction

    task automatic set_tr(input bit b, input logic v);
        if (b) tr_b = v; else tr_a = v;
    endtask

    task automatic set_wr(input bit b, input logic v);
        if (b) wr_b = v; else wr_a = v;
    endtask

    task automatic run_tile(input bit b, input int base, input int vp,
                            input int stall_beat, input int stall_len, input bit poke);
        int sys   = b ? 4 : 16;
        int plane = b ? 100 : 171396;
        int beat  = 0;
        logic [63:0] s;
        set_wr(b, 1'b1);
        set_tr(b, 1'b1);
        step();
        set_tr(b, 1'b0);
        for (int c = 0; c < sys; c++) begin
            for (int p = 0; p < vp; p++) begin
                check("beat", snap(b), beat_exp(c, p, base + c * plane + p));
                if (beat == stall_beat) begin
                    set_wr(b, 1'b0);
                    for (int k = 0; k < stall_len; k++) begin
                        step();
                        check("stall_hold", snap(b), beat_exp(c, p, base + c * plane + p));
                    end
                    set_wr(b, 1'b1);
                end
                if (poke && beat == 10) set_tr(b, 1'b1);
                step();
                if (poke && beat == 10) set_tr(b, 1'b0);
                beat++;
            end
        end
        s = snap(b);
        check("advance_flags", 64'(s[51:48]), 64'(4'b1100));
        step();
        s = snap(b);
        check("post_advance", 64'({s[50], s[48]}), 64'd0);
    endtask

    initial begin
        logic [63:0] s;
        int td_before;

        // Reset held with tile_ready asserted: reset must win.
        rst_n = 1'b0;
        tr_a = 1'b1; wr_a = 1'b1; tr_b = 1'b1; wr_b = 1'b1;
        step(); step(); step();
        check("reset_a", snap(0), 64'd0);
        check("reset_b", snap(1), 64'd0);
        tr_a = 1'b0; tr_b = 1'b0;
        rst_n = 1'b1;
        step();
        check("idle_after_reset", 64'(snap(0)[51:48]), 64'd0);

        // First tile, wr_ready tied high.
        run_tile(0, 0, 16, -1, 0, 0);

        // Second tile with a spurious tile_ready during WRITE.
        td_before = td_cnt_a;
        run_tile(0, 16, 16, -1, 0, 1);
        step(); step(); step();
        s = snap(0);
        check("no_queued_tile", 64'({s[51], s[48]}), 64'd0);
        check("tile_done_count", 64'(td_cnt_a - td_before), 64'd1);

        // Reset mid-WRITE while a beat is stalled.
        wr_a = 1'b1; tr_a = 1'b1;
        step();
        tr_a = 1'b0;
        repeat (5) step();
        check("pre_reset_beat", snap(0), beat_exp(0, 5, 37));
        wr_a = 1'b0;
        step();
        check("pre_reset_hold", snap(0), beat_exp(0, 5, 37));
        rst_n = 1'b0; tr_a = 1'b1; wr_a = 1'b1;
        step();
        rst_n = 1'b1; tr_a = 1'b0;
        check("mid_write_reset", snap(0), 64'd0);
        step();
        check("stay_idle_after_reset", snap(0), 64'd0);

        // First tile again, beat 3 (addr 2) stalled for 5 cycles.
        run_tile(0, 0, 16, 2, 5, 0);

        // Rest of row 0, including the 14-pixel edge tile, then row 1 start.
        for (int k = 1; k < 25; k++) run_tile(0, 16 * k, 16, -1, 0, 0);
        run_tile(0, 400, 14, -1, 0, 0);
        run_tile(0, 414, 16, -1, 0, 0);

        // Full layer on the small instance: 3 tiles per row (4,4,2 px), 10 rows.
        for (int t = 0; t < 30; t++) begin
            run_tile(1, (t / 3) * 10 + (t % 3) * 4, ((t % 3) == 2) ? 2 : 4, -1, 0, 0);
            check("layer_done_at_tile", 64'(snap(1)[49]), 64'(t == 29));
        end
        step();
        check("after_layer_idle", 64'(snap(1)[51:48]), 64'd0);
        check("layer_done_count", 64'(ld_cnt_b), 64'd1);
        run_tile(1, 0, 4, -1, 0, 0);
        check("layer_done_count_after", 64'(ld_cnt_b), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
